ads1220_ctrl: RTL and testbench
===============================

Name: ads1220_ctrl

Overview:
- Command/data sequencer that sits directly upstream of the 8-bit SPI byte engine in the ADS1220 path.
- Drives the engine's go/wrdat and consumes its rddat/ok.
- Brings the ADS1220 out of power-up: RESET command, WREG of config registers 0..3, START/SYNC.
- Then, on every DRDY falling edge, clocks out 3 bytes and presents a 24-bit signed conversion result with a one-cycle valid strobe.

Parameters:
- POWERUP_WAIT, 1000: clk cycles idle after reset before the first command.
- RESET_WAIT, 200: clk cycles after the RESET command before WREG.
- GAP, 3: minimum clk cycles spi_go is held low between bytes (must be >=2).
- DRDY_TIMEOUT, 1000000: clk cycles in WAIT_DRDY before timeout_err sets.

Ports:
- clk  in  1  system clock; the byte engine runs on the same clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg0, cfg1, cfg2, cfg3  in  8 each  ADS1220 register values; sampled when WREG_HDR is entered.
- cfg_update  in  1  one-cycle pulse; requests re-write of cfg0..3.
- drdy_n  in  1  ADS1220 DRDY pin, asynchronous, active-low.
- cs_n  out  1  ADS1220 chip select, active-low.
- spi_go  out  1  to byte engine go.
- spi_wrdat  out  8  to byte engine wrdat.
- spi_rddat  in  8  from byte engine rddat.
- spi_ok  in  1  from byte engine ok.
- adc_data  out  24  last conversion, two's complement, MSB byte first received.
- adc_valid  out  1  one-cycle strobe when adc_data updates.
- init_done  out  1  high once the first START has been sent; stays high until reset.
- timeout_err  out  1  sticky DRDY-timeout flag.

Behaviour:
- Reset values:
  - cs_n=1; spi_go=0; spi_wrdat=0; adc_data=0; adc_valid=0; init_done=0; timeout_err=0.
  - State=PWRUP, all counters 0, cfg_pending=0.
- drdy_n is synchronised with 2 FFs, plus a third FF for edge detect. A falling edge is sync=0 and prev=1.
- Byte transfer rule, applied per byte:
  - spi_wrdat is set at least 1 cycle before spi_go rises and held until spi_ok is seen high.
  - spi_go stays high until spi_ok=1 is sampled on a posedge.
  - spi_rddat is captured in that same cycle, and spi_go drops the next cycle.
  - spi_go then stays low for GAP cycles, which is the engine's counter/ok clear time.
  - Byte-to-byte spacing therefore never drops below GAP low cycles.
- cs_n:
  - Falls 1 cycle before the first spi_wrdat setup of a transaction.
  - Rises after the GAP following the last byte.
  - Transactions: RESET(1 byte), WREG(5), START(1), READ(3).
- States:
  - PWRUP: count POWERUP_WAIT, then RST_CMD.
  - RST_CMD: send 0x06, then RST_WAIT.
  - RST_WAIT: count RESET_WAIT, then WREG_HDR.
  - WREG_HDR: latch cfg0..3 and send 0x43 (WREG, start reg 0, 4 regs), then WREG_DATA.
  - WREG_DATA: send latched cfg0, cfg1, cfg2, cfg3 in that order (2-bit index), then START_CMD.
  - START_CMD: send 0x08; set init_done; clear cfg_pending and timeout_err; go to WAIT_DRDY with the timeout counter at 0.
  - WAIT_DRDY:
    - On DRDY falling edge: go to READ.
    - Else if cfg_pending: go to WREG_HDR.
    - Else increment the timeout counter. On reaching DRDY_TIMEOUT, set timeout_err, hold the counter saturated, and keep waiting.
  - READ: send 0x00 three times, capturing rddat into bits [23:16], [15:8], [7:0]. Then go to OUT.
  - OUT: load adc_data, pulse adc_valid for 1 cycle, clear the timeout counter, return to WAIT_DRDY.
- cfg_update:
  - A pulse in any state sets cfg_pending; it is serviced only from WAIT_DRDY.
  - A DRDY edge and a pending cfg in the same cycle: the read wins, and cfg is serviced on the next WAIT_DRDY cycle.
- DRDY edges arriving outside WAIT_DRDY are ignored; there is no queued read.
- adc_data holds its value between strobes; adc_valid is never high for 2 consecutive cycles.
- Async reset mid-transaction:
  - All outputs return to reset values immediately, and the full init sequence reruns.
  - The byte engine shares rst_n.

Test Plan:
- Init: release reset with cfg0..3=0x01,0x04,0x10,0x00 and drdy_n=1.
  - Bytes on spi_wrdat at each go: 0x06, then after ≥RESET_WAIT cycles 0x43,0x01,0x04,0x10,0x00, then 0x08.
  - cs_n is low during each transaction; init_done=1 after 0x08; spi_go low ≥GAP cycles between bytes.
- Read sign: drive a drdy_n falling edge with the MISO model returning 0x80,0x00,0x01.
  - Three 0x00 bytes are sent; adc_data=24'h800001 with a single-cycle adc_valid.
  - Repeat with 0x7F,0xFF,0xFF, which must give 24'h7FFFFF.
- Reconfig: pulse cfg_update in WAIT_DRDY with cfg1=0x24.
  - Sequence 0x43,cfg0,0x24,cfg2,cfg3,0x08 follows; no read is issued during it.
- Collision: cfg_update and a drdy_n falling edge in the same cycle.
  - Read completes with adc_valid first, then the WREG sequence.
- Timeout: hold drdy_n=1 for DRDY_TIMEOUT+10 cycles.
  - timeout_err=1 and stays set through a subsequent valid read.
  - It clears only after a cfg_update completes at START.
- Reset mid-read: assert rst_n low during the 2nd READ byte.
  - cs_n=1, spi_go=0, adc_valid=0 immediately; the PWRUP wait and the full init sequence then repeat.

Source files
------------

// File: rtl/ads1220_ctrl_if.sv
// Byte-level handshake between the ADS1220 sequencer (master) and the
// 8-bit SPI byte engine (slave).
interface ads1220_ctrl_if;
  logic       spi_go;
  logic [7:0] spi_wrdat;
  logic [7:0] spi_rddat;
  logic       spi_ok;

  modport master (output spi_go, output spi_wrdat, input spi_rddat, input spi_ok);
  modport slave  (input spi_go, input spi_wrdat, output spi_rddat, output spi_ok);
endinterface

// File: rtl/ads1220_ctrl.sv
// ADS1220 command/data sequencer: power-up init (RESET, WREG 0..3, START),
// then a 3-byte RDATA-less read on every DRDY falling edge.
module ads1220_ctrl #(
  parameter int POWERUP_WAIT = 1000,
  parameter int RESET_WAIT   = 200,
  parameter int GAP          = 3,
  parameter int DRDY_TIMEOUT = 1000000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            cfg0_i,
  input  logic [7:0]            cfg1_i,
  input  logic [7:0]            cfg2_i,
  input  logic [7:0]            cfg3_i,
  input  logic                  cfg_update_i,
  input  logic                  drdy_n_i,
  output logic                  cs_n_o,
  ads1220_ctrl_if.master        spi,
  output logic [23:0]           adc_data_o,
  output logic                  adc_valid_o,
  output logic                  init_done_o,
  output logic                  timeout_err_o
);

  localparam int WAIT_MAX = (POWERUP_WAIT > RESET_WAIT) ? POWERUP_WAIT : RESET_WAIT;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam int GW = $clog2(GAP + 1);
  localparam int TW = $clog2(DRDY_TIMEOUT + 1);

  localparam logic [7:0] CMD_RESET = 8'h06;
  localparam logic [7:0] CMD_WREG  = 8'h43;
  localparam logic [7:0] CMD_START = 8'h08;
  localparam logic [7:0] CMD_NOP   = 8'h00;

  typedef enum logic [3:0] {
    PWRUP, RST_CMD, RST_WAIT, WREG_HDR, WREG_DATA, START_CMD, WAIT_DRDY, READ, OUT
  } state_e;

  // Per-byte micro-sequence shared by every byte-sending state.
  typedef enum logic [1:0] {P_CS, P_SET, P_GO, P_GAP} phase_e;

  state_e           state_q;
  phase_e           ph_q;
  logic [WW-1:0]    wait_q;
  logic [GW-1:0]    gap_q;
  logic [TW-1:0]    tmo_q;
  logic [1:0]       idx_q;
  logic [3:0][7:0]  cfg_lat_q;
  logic [23:0]      rx_q;
  logic             cfg_pend_q;
  logic             cs_n_q, go_q, valid_q, init_q, terr_q;
  logic [7:0]       wrdat_q;
  logic [23:0]      data_q;
  logic             sync1_q, sync2_q, prev_q;
  logic             drdy_fall;
  logic [7:0]       tx_byte;

  // DRDY is asynchronous: two-flop synchroniser plus one flop for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= drdy_n_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign drdy_fall = ~sync2_q & prev_q;

  always_comb begin
    tx_byte = CMD_NOP;
    case (state_q)
      RST_CMD:   tx_byte = CMD_RESET;
      WREG_HDR:  tx_byte = CMD_WREG;
      WREG_DATA: tx_byte = cfg_lat_q[idx_q];
      START_CMD: tx_byte = CMD_START;
      default:   tx_byte = CMD_NOP;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PWRUP;
      ph_q       <= P_CS;
      wait_q     <= '0;
      gap_q      <= '0;
      tmo_q      <= '0;
      idx_q      <= '0;
      cfg_lat_q  <= '0;
      rx_q       <= '0;
      cfg_pend_q <= 1'b0;
      cs_n_q     <= 1'b1;
      go_q       <= 1'b0;
      wrdat_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      init_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        PWRUP: begin
          if (wait_q == WW'(POWERUP_WAIT - 1)) begin
            wait_q  <= '0;
            ph_q    <= P_CS;
            state_q <= RST_CMD;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end

        RST_WAIT: begin
          if (wait_q == WW'(RESET_WAIT - 1)) begin
            wait_q    <= '0;
            ph_q      <= P_CS;
            cfg_lat_q <= {cfg3_i, cfg2_i, cfg1_i, cfg0_i};
            state_q   <= WREG_HDR;
          end else begin
            wait_q <= wait_q + WW'(1);
          end
        end

        WAIT_DRDY: begin
          // A conversion in flight beats a pending reconfig; the reconfig
          // is picked up on the next WAIT_DRDY cycle.
          if (drdy_fall) begin
            idx_q   <= '0;
            ph_q    <= P_CS;
            state_q <= READ;
          end else if (cfg_pend_q) begin
            ph_q      <= P_CS;
            cfg_lat_q <= {cfg3_i, cfg2_i, cfg1_i, cfg0_i};
            state_q   <= WREG_HDR;
          end else if (tmo_q != TW'(DRDY_TIMEOUT)) begin
            tmo_q <= tmo_q + TW'(1);
            if (tmo_q == TW'(DRDY_TIMEOUT - 1)) terr_q <= 1'b1;
          end
        end

        OUT: begin
          data_q  <= rx_q;
          valid_q <= 1'b1;
          tmo_q   <= '0;
          state_q <= WAIT_DRDY;
        end

        RST_CMD, WREG_HDR, WREG_DATA, START_CMD, READ: begin
          case (ph_q)
            P_CS: begin
              cs_n_q <= 1'b0;
              ph_q   <= P_SET;
            end
            P_SET: begin
              wrdat_q <= tx_byte;
              ph_q    <= P_GO;
            end
            P_GO: begin
              go_q <= 1'b1;
              if (go_q && spi.spi_ok) begin
                go_q  <= 1'b0;
                rx_q  <= {rx_q[15:0], spi.spi_rddat};
                gap_q <= '0;
                ph_q  <= P_GAP;
              end
            end
            P_GAP: begin
              if (gap_q == GW'(GAP - 1)) begin
                gap_q <= '0;
                ph_q  <= P_SET;
                case (state_q)
                  RST_CMD: begin
                    cs_n_q  <= 1'b1;
                    wait_q  <= '0;
                    state_q <= RST_WAIT;
                  end
                  WREG_HDR: begin
                    idx_q   <= '0;
                    state_q <= WREG_DATA;
                  end
                  WREG_DATA: begin
                    if (idx_q == 2'd3) begin
                      cs_n_q  <= 1'b1;
                      ph_q    <= P_CS;
                      state_q <= START_CMD;
                    end else begin
                      idx_q <= idx_q + 2'd1;
                    end
                  end
                  START_CMD: begin
                    cs_n_q     <= 1'b1;
                    init_q     <= 1'b1;
                    cfg_pend_q <= 1'b0;
                    terr_q     <= 1'b0;
                    tmo_q      <= '0;
                    state_q    <= WAIT_DRDY;
                  end
                  default: begin
                    if (idx_q == 2'd2) begin
                      cs_n_q  <= 1'b1;
                      state_q <= OUT;
                    end else begin
                      idx_q <= idx_q + 2'd1;
                    end
                  end
                endcase
              end else begin
                gap_q <= gap_q + GW'(1);
              end
            end
            default: ph_q <= P_CS;
          endcase
        end

        default: state_q <= PWRUP;
      endcase

      // Placed last so a pulse coinciding with the START clear is kept.
      if (cfg_update_i) cfg_pend_q <= 1'b1;
    end
  end

  assign cs_n_o        = cs_n_q;
  assign spi.spi_go    = go_q;
  assign spi.spi_wrdat = wrdat_q;
  assign adc_data_o    = data_q;
  assign adc_valid_o   = valid_q;
  assign init_done_o   = init_q;
  assign timeout_err_o = terr_q;

endmodule

// File: tb/tb_ads1220_ctrl.sv
// Self-checking bench for ads1220_ctrl with a behavioural SPI byte engine.
module tb_ads1220_ctrl;
  localparam int PW = 40;
  localparam int RW = 20;
  localparam int GP = 3;
  localparam int TO = 300;

  typedef logic [7:0] bq_t[$];
  typedef struct {
    logic [7:0]  b0, b1, b2;
    logic [23:0] exp;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cfg0, cfg1, cfg2, cfg3;
  logic        cfg_update, drdy_n;
  logic        cs_n, adc_valid, init_done, timeout_err;
  logic [23:0] adc_data;

  always #5 clk = ~clk;

  ads1220_ctrl_if spi();

  ads1220_ctrl #(.POWERUP_WAIT(PW), .RESET_WAIT(RW), .GAP(GP), .DRDY_TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cfg0_i(cfg0), .cfg1_i(cfg1), .cfg2_i(cfg2), .cfg3_i(cfg3),
    .cfg_update_i(cfg_update), .drdy_n_i(drdy_n),
    .cs_n_o(cs_n), .spi(spi),
    .adc_data_o(adc_data), .adc_valid_o(adc_valid),
    .init_done_o(init_done), .timeout_err_o(timeout_err)
  );

  // Byte engine: raises ok a few cycles after go, clears it once go drops.
  logic [7:0] miso_q[$];
  int lat_cnt = 0;
  int lat_tgt = 2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spi.spi_ok    <= 1'b0;
      spi.spi_rddat <= 8'h00;
      lat_cnt       <= 0;
    end else if (spi.spi_go && !spi.spi_ok) begin
      if (lat_cnt >= lat_tgt) begin
        spi.spi_ok    <= 1'b1;
        spi.spi_rddat <= (miso_q.size() > 0) ? miso_q.pop_front() : 8'hFF;
        lat_cnt       <= 0;
        lat_tgt       <= int'($urandom_range(1, 6));
      end else begin
        lat_cnt <= lat_cnt + 1;
      end
    end else if (!spi.spi_go) begin
      spi.spi_ok <= 1'b0;
      lat_cnt    <= 0;
    end
  end

  // Bus monitor, sampled on the falling edge.
  logic [7:0] sent_q[$];
  int stamp_q[$];
  int cyc = 0, low_cnt = 0, valid_cnt = 0, bytes_at_valid = 0;
  int viol_gap = 0, viol_setup = 0, viol_hold = 0, viol_cs = 0, viol_valid = 0;
  logic go_prev = 1'b0, valid_prev = 1'b0;
  logic [7:0] wr_prev = 8'h00;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      low_cnt = 1 << 20;
      go_prev = 1'b0;
      valid_prev = 1'b0;
      wr_prev = spi.spi_wrdat;
    end else begin
      if (spi.spi_go && !go_prev) begin
        sent_q.push_back(spi.spi_wrdat);
        stamp_q.push_back(cyc);
        if (low_cnt < GP) viol_gap++;
        if (spi.spi_wrdat != wr_prev) viol_setup++;
      end
      if (spi.spi_go && go_prev && spi.spi_wrdat != wr_prev) viol_hold++;
      if (spi.spi_go && cs_n) viol_cs++;
      if (adc_valid && valid_prev) viol_valid++;
      if (adc_valid) begin
        valid_cnt++;
        bytes_at_valid = sent_q.size();
      end
      low_cnt    = spi.spi_go ? 0 : low_cnt + 1;
      go_prev    = spi.spi_go;
      wr_prev    = spi.spi_wrdat;
      valid_prev = adc_valid;
    end
  end

  int n_pass = 0, n_tot = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: command stream and result word derived from the device protocol.
  function automatic bq_t cfg_seq(input logic [7:0] c0, c1, c2, c3);
    bq_t q;
    q.push_back(8'h43);
    q.push_back(c0); q.push_back(c1); q.push_back(c2); q.push_back(c3);
    q.push_back(8'h08);
    return q;
  endfunction

  function automatic logic [23:0] model_word(input logic [7:0] b0, b1, b2);
    int w;
    w = int'(b0) * 65536 + int'(b1) * 256 + int'(b2);
    return w[23:0];
  endfunction

  task automatic wait_bytes(input int n, input int budget, input string nm);
    int t = 0;
    while (sent_q.size() < n && t < budget) begin @(posedge clk); t++; end
    chk({nm, " bytes arrive"}, 32'(sent_q.size() >= n), 32'd1);
  endtask

  task automatic expect_bytes(input string nm, input bq_t exp);
    logic [7:0] got;
    for (int i = 0; i < exp.size(); i++) begin
      got = 8'hxx;
      if (sent_q.size() > 0) begin
        got = sent_q.pop_front();
        void'(stamp_q.pop_front());
      end
      chk($sformatf("%s byte%0d", nm, i), 32'(got), 32'(exp[i]));
    end
  endtask

  task automatic wait_quiet(input int budget);
    int t = 0;
    while ((!cs_n || spi.spi_go) && t < budget) begin @(posedge clk); t++; end
    repeat (4) tick();
  endtask

  task automatic init_check(input string nm, input logic [7:0] c0, c1, c2, c3);
    bq_t e;
    int rel, s0, s1;
    e = cfg_seq(c0, c1, c2, c3);
    e.push_front(8'h06);
    rst_n = 1'b1;
    rel = cyc;
    wait_bytes(7, PW + RW + 600, nm);
    s0 = (stamp_q.size() > 0) ? stamp_q[0] : rel;
    s1 = (stamp_q.size() > 1) ? stamp_q[1] : s0;
    chk({nm, " powerup wait"}, 32'((s0 - rel) >= PW), 32'd1);
    chk({nm, " reset wait"}, 32'((s1 - s0) >= RW), 32'd1);
    expect_bytes(nm, e);
    wait_quiet(100);
    chk({nm, " init_done"}, 32'(init_done), 32'd1);
    chk({nm, " cs_n idle"}, 32'(cs_n), 32'd1);
  endtask

  task automatic do_read(input string nm, input logic [7:0] b0, b1, b2);
    int v0, t;
    logic [23:0] exp;
    bq_t rd;
    rd = '{8'h00, 8'h00, 8'h00};
    exp = model_word(b0, b1, b2);
    miso_q.push_back(b0); miso_q.push_back(b1); miso_q.push_back(b2);
    v0 = valid_cnt;
    drdy_n = 1'b0;
    repeat (4) tick();
    drdy_n = 1'b1;
    t = 0;
    while (valid_cnt == v0 && t < 400) begin @(posedge clk); t++; end
    chk({nm, " valid seen"}, 32'(valid_cnt - v0), 32'd1);
    chk({nm, " adc_data"}, 32'(adc_data), 32'(exp));
    expect_bytes(nm, rd);
    repeat (10) tick();
    chk({nm, " data held"}, 32'(adc_data), 32'(exp));
  endtask

  vec_t tbl[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t e;
    int v0;
    logic [7:0] r0, r1, r2;

    tbl[0] = '{8'h80, 8'h00, 8'h01, 24'h800001};
    tbl[1] = '{8'h7F, 8'hFF, 8'hFF, 24'h7FFFFF};
    tbl[2] = '{8'hFF, 8'hFF, 8'hFF, 24'hFFFFFF};
    tbl[3] = '{8'h00, 8'h00, 8'h00, 24'h000000};

    cfg0 = 8'h01; cfg1 = 8'h04; cfg2 = 8'h10; cfg3 = 8'h00;
    cfg_update = 1'b0;
    drdy_n = 1'b1;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst cs_n", 32'(cs_n), 32'd1);
    chk("rst spi_go", 32'(spi.spi_go), 32'd0);
    chk("rst spi_wrdat", 32'(spi.spi_wrdat), 32'd0);
    chk("rst adc_data", 32'(adc_data), 32'd0);
    chk("rst adc_valid", 32'(adc_valid), 32'd0);
    chk("rst init_done", 32'(init_done), 32'd0);
    chk("rst timeout_err", 32'(timeout_err), 32'd0);

    init_check("init", 8'h01, 8'h04, 8'h10, 8'h00);

    foreach (tbl[i]) do_read($sformatf("vec%0d", i), tbl[i].b0, tbl[i].b1, tbl[i].b2);

    for (int i = 0; i < 6; i++) begin
      r0 = 8'($urandom_range(0, 255));
      r1 = 8'($urandom_range(0, 255));
      r2 = 8'($urandom_range(0, 255));
      do_read($sformatf("rnd%0d", i), r0, r1, r2);
    end

    // Reconfig; a DRDY edge landing mid-WREG must not start a read.
    cfg1 = 8'h24;
    v0 = valid_cnt;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    repeat (10) tick();
    drdy_n = 1'b0;
    repeat (4) tick();
    drdy_n = 1'b1;
    wait_bytes(6, 400, "reconfig");
    expect_bytes("reconfig", cfg_seq(8'h01, 8'h24, 8'h10, 8'h00));
    repeat (40) tick();
    chk("reconfig no read", 32'(sent_q.size()), 32'd0);
    chk("reconfig no valid", 32'(valid_cnt - v0), 32'd0);

    // Collision: cfg_update lags the pin by one cycle so both reach the
    // WAIT_DRDY decision together after the DRDY synchroniser.
    miso_q.push_back(8'h12); miso_q.push_back(8'h34); miso_q.push_back(8'h56);
    v0 = valid_cnt;
    drdy_n = 1'b0;
    tick();
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    repeat (3) tick();
    drdy_n = 1'b1;
    wait_bytes(9, 600, "collision");
    e = cfg_seq(8'h01, 8'h24, 8'h10, 8'h00);
    e.push_front(8'h00); e.push_front(8'h00); e.push_front(8'h00);
    chk("collision valid count", 32'(valid_cnt - v0), 32'd1);
    chk("collision valid before wreg", 32'(bytes_at_valid), 32'd3);
    chk("collision adc_data", 32'(adc_data), 32'(model_word(8'h12, 8'h34, 8'h56)));
    expect_bytes("collision", e);
    wait_quiet(100);
    repeat (30) tick();

    // Timeout: sticky through a read, cleared by a completed reconfig.
    repeat (TO / 2) tick();
    chk("timeout early", 32'(timeout_err), 32'd0);
    repeat (TO / 2 + 40) tick();
    chk("timeout set", 32'(timeout_err), 32'd1);
    do_read("tmo read", 8'hA5, 8'h5A, 8'h3C);
    chk("timeout sticky", 32'(timeout_err), 32'd1);
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
    wait_bytes(6, 400, "tmo reconfig");
    chk("timeout held in wreg", 32'(timeout_err), 32'd1);
    expect_bytes("tmo reconfig", cfg_seq(8'h01, 8'h24, 8'h10, 8'h00));
    wait_quiet(100);
    chk("timeout cleared", 32'(timeout_err), 32'd0);

    // Reset during the second READ byte.
    miso_q.push_back(8'h11); miso_q.push_back(8'h22); miso_q.push_back(8'h33);
    drdy_n = 1'b0;
    wait_bytes(2, 300, "midread");
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst cs_n", 32'(cs_n), 32'd1);
    chk("midrst spi_go", 32'(spi.spi_go), 32'd0);
    chk("midrst adc_valid", 32'(adc_valid), 32'd0);
    chk("midrst init_done", 32'(init_done), 32'd0);
    chk("midrst adc_data", 32'(adc_data), 32'd0);
    miso_q.delete();
    sent_q.delete();
    stamp_q.delete();
    drdy_n = 1'b1;
    repeat (3) tick();
    init_check("reinit", 8'h01, 8'h24, 8'h10, 8'h00);
    do_read("post reinit", 8'h80, 8'h00, 8'h01);

    chk("gap violations", 32'(viol_gap), 32'd0);
    chk("setup violations", 32'(viol_setup), 32'd0);
    chk("hold violations", 32'(viol_hold), 32'd0);
    chk("cs violations", 32'(viol_cs), 32'd0);
    chk("valid width violations", 32'(viol_valid), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
